// File: rtl/bcd_display_mux.sv
// Time-multiplexed 4-digit 7-segment driver for a packed BCD word, with a
// frame-aligned pending buffer, leading-zero blanking and per-digit decimal points.
module bcd_display_mux #(
  parameter int unsigned PRESCALE       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CNT_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned IDX_W    = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [6:0] SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF    = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } word_t;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic             commit;

  word_t in_word;
  word_t disp_q;
  word_t pend_q;
  logic  pend_valid;
  word_t disp_nxt;
  word_t pend_nxt;
  logic  pend_valid_nxt;

  logic [3:0]       nib_c;
  logic             blank_c;
  logic [6:0]       seg_pat_c;
  logic             dp_pat_c;
  logic [DIGITS-1:0] an_pat_c;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = SEG_DASH;
    endcase
    return p;
  endfunction

  assign in_word  = {bcd_in, dp_in};
  assign tick     = (cnt == CNT_MAX);
  assign next_idx = IDX_W'(idx + IDX_W'(1));
  assign commit   = tick && (next_idx == '0);

  // Slot prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= CNT_W'(cnt + CNT_W'(1));
    end
  end

  // Digit scan index; starts at 3 so the first tick selects digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= IDX_W'(DIGITS - 1);
    end else if (tick) begin
      idx <= next_idx;
    end
  end

  // Buffer next-state: a load on the commit edge bypasses the pending slot
  always_comb begin
    disp_nxt       = disp_q;
    pend_nxt       = pend_q;
    pend_valid_nxt = pend_valid;
    if (commit) begin
      if (load) begin
        disp_nxt = in_word;
      end else if (pend_valid) begin
        disp_nxt = pend_q;
      end
      pend_valid_nxt = 1'b0;
    end else if (load) begin
      pend_nxt       = in_word;
      pend_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= '0;
      pend_q     <= '0;
      pend_valid <= 1'b0;
    end else begin
      disp_q     <= disp_nxt;
      pend_q     <= pend_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

  // Pattern for the digit entering its slot, taken from the post-commit word
  always_comb begin
    nib_c     = disp_nxt.bcd[{next_idx, 2'b00} +: 4];
    blank_c   = 1'b0;
    seg_pat_c = seg_decode(nib_c);
    dp_pat_c  = disp_nxt.dp[next_idx];
    an_pat_c  = DIGITS'(1) << next_idx;
    case (next_idx)
      2'd3:    blank_c = blank_en && (disp_nxt.bcd[15:12] == 4'h0);
      2'd2:    blank_c = blank_en && (disp_nxt.bcd[15:8] == 8'h00);
      2'd1:    blank_c = blank_en && (disp_nxt.bcd[15:4] == 12'h000);
      default: blank_c = 1'b0;
    endcase
    if (blank_c) begin
      seg_pat_c = SEG_BLANK;
      dp_pat_c  = 1'b0;
      an_pat_c  = '0;
    end
  end

  // Pin registers: update only on slot boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else if (tick) begin
      seg <= SEG_ACTIVE_LOW ? ~seg_pat_c : seg_pat_c;
      dp  <= SEG_ACTIVE_LOW ? ~dp_pat_c  : dp_pat_c;
      an  <= AN_ACTIVE_LOW  ? ~an_pat_c  : an_pat_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomized and directed bench for bcd_display_mux (PRESCALE=4, low-true pins),
// compared cycle by cycle against an arithmetic reference of the display behaviour.
module tb_bcd_display_mux;

  localparam int P = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  bcd_display_mux #(.PRESCALE(P), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_en(blank_en), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [6:0]  seg_tab [16];
  int          edges;
  logic [15:0] m_disp;
  logic [3:0]  m_disp_dp;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  logic        m_has_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fd;
  logic        m_tick;
  int          m_digit;
  logic        cur_be;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    edges = 0; m_disp = '0; m_disp_dp = '0; m_pend = '0; m_pend_dp = '0;
    m_has_pend = 1'b0; e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
    m_tick = 1'b0; m_digit = -1;
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] b, input logic [3:0] d, input logic be);
    logic commit;
    logic blank;
    int nib;
    edges++;
    m_tick = ((edges % P) == 0);
    commit = 1'b0;
    if (m_tick) begin
      m_digit = (edges / P - 1) % 4;
      commit = (m_digit == 0);
    end
    if (commit) begin
      if (ld) begin m_disp = b; m_disp_dp = d; end
      else if (m_has_pend) begin m_disp = m_pend; m_disp_dp = m_pend_dp; end
      m_has_pend = 1'b0;
    end else if (ld) begin
      m_pend = b; m_pend_dp = d; m_has_pend = 1'b1;
    end
    if (m_tick) begin
      nib   = (m_disp >> (4 * m_digit)) & 16'hF;
      blank = be && (m_digit != 0) && ((m_disp >> (4 * m_digit)) == 0);
      e_seg = blank ? 7'h7F : ~seg_tab[nib];
      e_dp  = blank ? 1'b1 : ~m_disp_dp[m_digit];
      e_an  = blank ? 4'hF : ~(4'b0001 << m_digit);
    end
    e_fd = commit;
  endtask

  // One clock: drive inputs, advance model, compare all pins 1 time unit after the edge
  task automatic cycle(input logic ld, input logic [15:0] b, input logic [3:0] d);
    load = ld; bcd_in = b; dp_in = d; blank_en = cur_be;
    @(posedge clk);
    model_edge(ld, b, d, cur_be);
    #1;
    chk("pins", {19'd0, seg, dp, an, frame_done}, {19'd0, e_seg, e_dp, e_an, e_fd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0);
  endtask

  task automatic run_to_digit(input int d);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 16'h0, 4'h0);
      if (m_tick && m_digit == d) found = 1;
    end
    if (!found) chk("digit_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {19'd0, seg, dp, an, frame_done}, {19'd0, 7'h7F, 1'b1, 4'hF, 1'b0});
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold", {19'd0, seg, dp, an, frame_done}, {19'd0, 7'h7F, 1'b1, 4'hF, 1'b0});
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    int r;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 7);
      if (r <= 2)      w[4*i +: 4] = 4'h0;
      else if (r == 3) w[4*i +: 4] = 4'(10 + $urandom_range(0, 5));
      else             w[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return w;
  endfunction

  initial begin
    int fd_cnt;
    int guard;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; blank_en = 1'b0; cur_be = 1'b0;
    model_reset();
    do_reset();
    idle(6);
    do_reset();

    // 1234 loaded before the first tick, scanned with low-true pins
    cycle(1'b1, 16'h1234, 4'h0);
    run_to_digit(0); chk("d0_seg", 32'(seg), 32'h19); chk("d0_an", 32'(an), 32'hE);
    run_to_digit(1); chk("d1_seg", 32'(seg), 32'h30); chk("d1_an", 32'(an), 32'hD);
    run_to_digit(2); chk("d2_seg", 32'(seg), 32'h24); chk("d2_an", 32'(an), 32'hB);
    run_to_digit(3); chk("d3_seg", 32'(seg), 32'h79); chk("d3_an", 32'(an), 32'h7);
    fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 16'h0, 4'h0);
      if (frame_done) fd_cnt++;
    end
    chk("fd_per_32", 32'(fd_cnt), 32'd2);

    // Leading-zero blanking
    cur_be = 1'b1;
    cycle(1'b1, 16'h0050, 4'h0);
    run_to_digit(0); chk("b_d0_seg", 32'(seg), 32'h40);
    run_to_digit(1); chk("b_d1_seg", 32'(seg), 32'h12);
    run_to_digit(2); chk("b_d2_an", 32'(an), 32'hF); chk("b_d2_seg", 32'(seg), 32'h7F);
    run_to_digit(3); chk("b_d3_an", 32'(an), 32'hF);
    cycle(1'b1, 16'h0000, 4'h0);
    run_to_digit(0); chk("z_d0_seg", 32'(seg), 32'h40); chk("z_d0_an", 32'(an), 32'hE);
    run_to_digit(1); chk("z_d1_an", 32'(an), 32'hF);

    // Invalid nibble and decimal point, no blanking
    cur_be = 1'b0;
    cycle(1'b1, 16'h00A0, 4'b0010);
    run_to_digit(0); chk("i_d0_dp", 32'(dp), 32'd1);
    run_to_digit(1); chk("i_d1_seg", 32'(seg), 32'h3F); chk("i_d1_dp", 32'(dp), 32'd0);
    run_to_digit(2); chk("i_d2_seg", 32'(seg), 32'h40); chk("i_d2_dp", 32'(dp), 32'd1);

    // Tear-free: a load mid-frame takes effect only at the next frame
    cycle(1'b1, 16'h1111, 4'h0);
    run_to_digit(0);
    run_to_digit(2); chk("t_d2_old", 32'(seg), 32'h79);
    cycle(1'b1, 16'h2222, 4'h0);
    run_to_digit(3); chk("t_d3_old", 32'(seg), 32'h79);
    run_to_digit(0); chk("t_d0_new", 32'(seg), 32'h24);
    run_to_digit(1); chk("t_d1_new", 32'(seg), 32'h24);

    // Load exactly on the commit edge
    guard = 0;
    while (!(((edges + 1) % P) == 0 && (((edges + 1) / P - 1) % 4) == 0) && guard < 40) begin
      cycle(1'b0, 16'h0, 4'h0);
      guard++;
    end
    cycle(1'b1, 16'h5555, 4'h0);
    chk("c_d0_seg", 32'(seg), 32'h12); chk("c_d0_an", 32'(an), 32'hE);
    chk("c_fd", 32'(frame_done), 32'd1);
    run_to_digit(0); chk("c_next_seg", 32'(seg), 32'h12);

    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if ($urandom_range(0, 31) == 0) cur_be = ~cur_be;
      if ($urandom_range(0, 7) == 0) cycle(1'b1, rand_bcd(), 4'($urandom_range(0, 15)));
      else cycle(1'b0, 16'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
